// File: rtl/hub75_bcm_driver.sv
`timescale 1ns/1ps
// HUB75 LED panel scan driver with binary-coded-modulation brightness.
// Reads one row-pair of pixels per bit plane, shifts it out, latches, then displays.
//
// state   | meaning
// IDLE    | panel blanked, waiting for enable
// SHIFT   | read-lead cycle, then two cycles per column (data, led_clk high)
// BLANK   | one blanked cycle, row address switches
// LATCH   | latch pulse
// DISPLAY | oe active for BASE_TIME<<plane cycles
module hub75_bcm_driver #(
  parameter int COLS      = 32,
  parameter int ROW_BITS  = 4,
  parameter int DEPTH     = 4,
  parameter int BASE_TIME = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  output logic                             rd_en,
  output logic [ROW_BITS+$clog2(COLS)-1:0] rd_addr,
  input  logic [6*DEPTH-1:0]               rd_data,
  output logic                             r1,
  output logic                             g1,
  output logic                             b1,
  output logic                             r2,
  output logic                             g2,
  output logic                             b2,
  output logic [ROW_BITS-1:0]              addr,
  output logic                             lat,
  output logic                             oe,
  output logic                             led_clk,
  output logic                             frame_done
);

  localparam int CB = $clog2(COLS);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2((BASE_TIME << (DEPTH-1)) + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SHIFT   = 3'd1;
  localparam logic [2:0] BLANK   = 3'd2;
  localparam logic [2:0] LATCH   = 3'd3;
  localparam logic [2:0] DISPLAY = 3'd4;

  localparam logic [CB-1:0]       LAST_COL   = CB'(COLS-1);
  localparam logic [PW-1:0]       LAST_PLANE = PW'(DEPTH-1);
  localparam logic [ROW_BITS-1:0] LAST_ROW   = '1;

  logic [2:0]          state;
  logic [ROW_BITS-1:0] row;
  logic [PW-1:0]       plane;
  logic [CB-1:0]       col;
  logic [CB-1:0]       col_rd;
  logic                lead;
  logic                phase;
  logic [CW-1:0]       cnt;
  logic [5:0]          rgb_q;
  logic [5:0]          rgb_new;
  logic                shift_p0;

  // Bit `plane` of each channel; rgb vectors are ordered {r1,g1,b1,r2,g2,b2}.
  always_comb begin
    rgb_new = '0;
    for (int k = 0; k < 6; k++) begin
      rgb_new[k] = rd_data[k*DEPTH + int'(plane)];
    end
  end

  assign shift_p0 = (state == SHIFT) && !lead && !phase;
  assign {r1, g1, b1, r2, g2, b2} = shift_p0 ? rgb_new : rgb_q;

  // In phase 1 the read for the next column goes out, so data lands in its phase 0.
  assign col_rd  = phase ? col + CB'(1) : col;
  assign rd_addr = {row, col_rd};
  assign rd_en   = (state == SHIFT) && (lead || (phase && (col != LAST_COL)));
  assign led_clk = (state == SHIFT) && !lead && phase;
  assign lat     = (state == LATCH);
  assign oe      = (state != DISPLAY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      row        <= '0;
      plane      <= '0;
      col        <= '0;
      lead       <= 1'b0;
      phase      <= 1'b0;
      cnt        <= '0;
      rgb_q      <= '0;
      addr       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (shift_p0) rgb_q <= rgb_new;
      case (state)
        IDLE: begin
          if (enable) begin
            state <= SHIFT;
            row   <= '0;
            plane <= '0;
            col   <= '0;
            lead  <= 1'b1;
            phase <= 1'b0;
          end
        end
        SHIFT: begin
          if (lead) begin
            lead  <= 1'b0;
            phase <= 1'b0;
          end else if (!phase) begin
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (col == LAST_COL) begin
              col   <= '0;
              addr  <= row;
              state <= BLANK;
            end else begin
              col <= col + CB'(1);
            end
          end
        end
        BLANK: state <= LATCH;
        LATCH: begin
          cnt   <= CW'((BASE_TIME << plane) - 1);
          state <= DISPLAY;
        end
        DISPLAY: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (plane != LAST_PLANE) begin
            plane <= plane + PW'(1);
            lead  <= 1'b1;
            state <= SHIFT;
          end else begin
            // Row boundary is the only point where enable is honoured.
            plane <= '0;
            row   <= row + ROW_BITS'(1);
            if (row == LAST_ROW) frame_done <= 1'b1;
            if (enable) begin
              lead  <= 1'b1;
              state <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_bcm_driver.sv
`timescale 1ns/1ps
// Directed bench for hub75_bcm_driver: cycle-exact frame trace plus enable-drop and reset-abort sequences.
module tb_hub75_bcm_driver;

  localparam int COLS      = 4;
  localparam int ROW_BITS  = 1;
  localparam int DEPTH     = 2;
  localparam int BASE_TIME = 2;
  localparam logic [2:0] ST_SHIFT = 3'd1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [11:0] rd_data = '0;
  logic        r1, g1, b1, r2, g2, b2;
  logic [0:0]  addr;
  logic        lat, oe, led_clk, frame_done;
  logic [5:0]  rgb;

  int n_total = 0;
  int n_pass  = 0;

  hub75_bcm_driver #(.COLS(COLS), .ROW_BITS(ROW_BITS), .DEPTH(DEPTH), .BASE_TIME(BASE_TIME)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .addr(addr), .lat(lat), .oe(oe), .led_clk(led_clk), .frame_done(frame_done)
  );

  assign rgb = {r1, g1, b1, r2, g2, b2};

  always #5 clk = ~clk;

  // Pixel buffer model: r1 is always {plane1=1, plane0=0}; other channels vary with address.
  function automatic logic [11:0] pix(input logic [2:0] a);
    logic       rw;
    logic [1:0] c;
    rw = a[2];
    c  = a[1:0];
    return {2'b10, c, {rw, rw}, ~c, 2'b01, {c[0], rw}};
  endfunction

  function automatic logic [5:0] bits_of(input logic [11:0] p, input int pl);
    logic [5:0] b;
    for (int k = 0; k < 6; k++) b[k] = p[k*2 + pl];
    return b;
  endfunction

  always @(posedge clk) if (rd_en) rd_data <= pix(rd_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Continuous properties, sampled mid-cycle.
  logic [0:0] prev_addr = '0;
  always @(negedge clk) begin
    if (reset) begin
      check("prop_lat_oe", {31'd0, lat && !oe}, 32'd0);
      if (addr != prev_addr) check("prop_addr_blank", {31'd0, oe}, 32'd1);
      if (dut.state != ST_SHIFT) check("prop_ledclk_idle", {31'd0, led_clk}, 32'd0);
    end
    prev_addr = addr;
  end

  typedef struct {
    int row;
    int plane;
    int disp;
  } seg_t;
  seg_t segs[4];

  logic [5:0] exp_rgb  = '0;
  logic [0:0] exp_addr = '0;

  task automatic run_frame(input int frame_idx);
    logic [4:0] ectl;
    logic [2:0] ea;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      ectl = {1'b1, 1'b0, 1'b0, 1'b1, (s == 0 && frame_idx > 0)};
      ea   = {1'(segs[s].row), 2'd0};
      check("lead_ctl", {27'd0, rd_en, led_clk, lat, oe, frame_done}, {27'd0, ectl});
      check("lead_rdaddr", {29'd0, rd_addr}, {29'd0, ea});
      check("lead_rgb", {26'd0, rgb}, {26'd0, exp_rgb});
      for (int c = 0; c < COLS; c++) begin
        @(negedge clk);
        exp_rgb = bits_of(pix({1'(segs[s].row), 2'(c)}), segs[s].plane);
        check("p0_ctl", {27'd0, rd_en, led_clk, lat, oe, frame_done}, 32'b00010);
        check("p0_rgb", {26'd0, rgb}, {26'd0, exp_rgb});
        @(negedge clk);
        ectl = {(c < COLS-1), 1'b1, 1'b0, 1'b1, 1'b0};
        check("p1_ctl", {27'd0, rd_en, led_clk, lat, oe, frame_done}, {27'd0, ectl});
        check("p1_rgb", {26'd0, rgb}, {26'd0, exp_rgb});
        if (c < COLS-1) begin
          ea = {1'(segs[s].row), 2'(c+1)};
          check("p1_rdaddr", {29'd0, rd_addr}, {29'd0, ea});
        end
      end
      @(negedge clk);
      exp_addr = 1'(segs[s].row);
      check("blank_ctl", {27'd0, rd_en, led_clk, lat, oe, frame_done}, 32'b00010);
      check("blank_addr", {31'd0, addr}, {31'd0, exp_addr});
      @(negedge clk);
      check("latch_ctl", {27'd0, rd_en, led_clk, lat, oe, frame_done}, 32'b00110);
      check("latch_addr", {31'd0, addr}, {31'd0, exp_addr});
      for (int d = 0; d < segs[s].disp; d++) begin
        @(negedge clk);
        check("disp_ctl", {27'd0, rd_en, led_clk, lat, oe, frame_done}, 32'b00000);
        check("disp_rgb", {26'd0, rgb}, {26'd0, exp_rgb});
        check("disp_addr", {31'd0, addr}, {31'd0, exp_addr});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat_cnt, oe_low, fd_cnt, rd_cnt, waited;
    logic found;

    segs[0] = '{0, 0, 2};
    segs[1] = '{0, 1, 4};
    segs[2] = '{1, 0, 2};
    segs[3] = '{1, 1, 4};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_oe", {31'd0, oe}, 32'd1);
    check("reset_outs", {15'd0, rd_en, rd_addr, rgb, addr, lat, led_clk, frame_done}, 32'd0);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_outs", {15'd0, rd_en, rd_addr, rgb, addr, lat, led_clk, frame_done, oe}, 32'd1);
    end

    // Three continuous frames, cycle-exact
    enable = 1'b1;
    for (int f = 0; f < 3; f++) run_frame(f);
    @(negedge clk);
    check("frame3_fd", {31'd0, frame_done}, 32'd1);

    // Drop enable during row 0, plane 0 DISPLAY
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (lat) found = 1'b1;
    end
    check("drop_lat_seen", {31'd0, found}, 32'd1);
    @(negedge clk);
    check("drop_in_disp", {31'd0, oe}, 32'd0);
    enable = 1'b0;
    lat_cnt = 0; oe_low = 0; fd_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (lat) lat_cnt++;
      if (!oe) oe_low++;
      if (frame_done) fd_cnt++;
    end
    check("drop_lat_cnt", lat_cnt, 1);
    check("drop_oe_low", oe_low, 5);
    check("drop_fd_cnt", fd_cnt, 0);
    check("drop_idle", {28'd0, oe, rd_en, led_clk, addr}, 32'b1000);

    // Reset during SHIFT column 2
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b1;
    rd_cnt = 0;
    for (int i = 0; i < 40 && rd_cnt < 3; i++) begin
      @(negedge clk);
      if (rd_en) rd_cnt++;
    end
    check("rst_rd3_addr", {29'd0, rd_addr}, 32'd2);
    @(negedge clk);
    @(negedge clk);
    check("rst_col2_ledclk", {31'd0, led_clk}, 32'd1);
    reset = 1'b0;
    #1;
    check("rst_immediate", {27'd0, oe, led_clk, rd_en, lat, frame_done}, 32'b10000);
    check("rst_rdaddr", {29'd0, rd_addr}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    found = 1'b0; waited = 0; lat_cnt = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      waited++;
      if (lat) lat_cnt++;
      if (rd_en) found = 1'b1;
    end
    check("rst_restart_seen", {31'd0, found}, 32'd1);
    check("rst_restart_wait", waited, 1);
    check("rst_restart_addr", {29'd0, rd_addr}, 32'd0);
    check("rst_no_lat", lat_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
